// File: rtl/instr_trace_buffer.sv
// rtl/instr_trace_buffer.sv - circular instruction/PC trace buffer with wrap, fill and pre/post trigger capture
module instr_trace_buffer #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 64,
    parameter int DEPTH       = 16,
    parameter int POST_TRIG   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       stop,
    input  logic [1:0]                 mode,
    input  logic                       filt_en,
    input  logic [6:0]                 match_op,
    input  logic [6:0]                 match_mask,
    input  logic                       in_valid,
    input  logic [INSTR_WIDTH-1:0]     in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [INSTR_WIDTH-1:0]     rd_instr,
    output logic [PC_WIDTH-1:0]        rd_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       triggered,
    output logic [1:0]                 state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
    localparam logic [CW-1:0] POST_M1  = CW'(POST_TRIG - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t cur_state, nxt_state;

    logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
    logic [PC_WIDTH-1:0]    mem_pc    [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] post_cnt, post_nxt;
    logic [1:0]    mode_q;
    logic          filt_q;

    logic match, eligible, full, pop, wr, trig, overwrite;
    logic fill_q, trig_q;

    assign state    = cur_state;
    assign match    = ((in_instr[6:0] ^ match_op) & match_mask) == 7'd0;
    assign eligible = in_valid && (!filt_q || match);
    assign full     = (count == FULL_CNT);
    assign pop      = rd_en && (count != '0) && !arm;
    assign fill_q   = (mode_q == 2'd1);
    assign trig_q   = (mode_q == 2'd2);
    assign overwrite = wr && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        wr        = 1'b0;
        trig      = 1'b0;
        post_nxt  = post_cnt;
        case (cur_state)
            S_ARMED: begin
                // the trigger is stored even when the filter would reject it
                trig = in_valid && match;
                wr   = eligible || trig;
                if (trig) begin
                    post_nxt  = POST_M1;
                    nxt_state = (POST_M1 == '0) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (fill_q) begin
                    wr = eligible && (!full || pop);
                    if (wr && !pop && (count == LAST_CNT)) begin
                        nxt_state = S_DONE;
                    end
                end else begin
                    wr = eligible;
                    if (trig_q && wr) begin
                        if (post_cnt != '0) begin
                            post_nxt = post_cnt - 1'b1;
                        end
                        if (post_cnt <= CW'(1)) begin
                            nxt_state = S_DONE;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
        if (stop) begin
            nxt_state = S_DONE;
        end
        if (arm) begin
            wr        = 1'b0;
            trig      = 1'b0;
            post_nxt  = '0;
            nxt_state = (mode == 2'd2) ? S_ARMED : S_CAPTURE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
            post_cnt  <= '0;
            mode_q    <= 2'd0;
            filt_q    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_instr  <= '0;
            rd_pc     <= '0;
        end else if (arm) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
            post_cnt  <= '0;
            mode_q    <= mode;
            filt_q    <= filt_en;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_instr <= mem_instr[rd_ptr];
                rd_pc    <= mem_pc[rd_ptr];
            end
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr && !pop && !full) begin
                count <= count + 1'b1;
            end else if (pop && !wr) begin
                count <= count - 1'b1;
            end
            // discarding old history is the point of trigger mode, so it is not an overflow
            if (overwrite && !trig_q) begin
                overflow <= 1'b1;
            end
            if (trig) begin
                triggered <= 1'b1;
            end
            post_cnt <= post_nxt;
        end
    end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// tb/tb_instr_trace_buffer.sv - directed and random checks of instr_trace_buffer against a queue model
module tb_instr_trace_buffer;

    localparam int IW = 32;
    localparam int PW = 64;
    localparam int D  = 4;
    localparam int PT = 2;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm, stop;
    logic [1:0]    mode;
    logic          filt_en;
    logic [6:0]    match_op, match_mask;
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic [PW-1:0] in_pc;
    logic          rd_en;
    logic          rd_valid;
    logic [IW-1:0] rd_instr;
    logic [PW-1:0] rd_pc;
    logic [2:0]    count;
    logic          overflow, triggered;
    logic [1:0]    state;

    always #5 clk = ~clk;

    instr_trace_buffer #(
        .INSTR_WIDTH(IW), .PC_WIDTH(PW), .DEPTH(D), .POST_TRIG(PT)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .mode(mode),
        .filt_en(filt_en), .match_op(match_op), .match_mask(match_mask),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_instr(rd_instr), .rd_pc(rd_pc), .count(count),
        .overflow(overflow), .triggered(triggered), .state(state)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [PW-1:0] pc;
    } ent_t;

    ent_t          q[$];
    int            m_state, m_mode, m_left;
    bit            m_filt, m_ovf, m_trg, m_rdv;
    logic [IW-1:0] m_rdi;
    logic [PW-1:0] m_rdp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0; m_mode = 0; m_left = 0;
        m_filt = 0; m_ovf = 0; m_trg = 0; m_rdv = 0;
        m_rdi = '0; m_rdp = '0;
    endtask

    // one clock of the capture rules, applied to the queue before the edge
    task automatic model_step();
        bit   match, elig, dop, store, tnow;
        int   ns;
        ent_t e;
        if (arm) begin
            q.delete();
            m_ovf = 0; m_trg = 0; m_rdv = 0;
            m_mode = int'(mode); m_filt = filt_en;
            m_state = (mode == 2'd2) ? 1 : 2;
            return;
        end
        match = ((in_instr[6:0] ^ match_op) & match_mask) == 7'd0;
        elig  = in_valid && (!m_filt || match);
        dop   = rd_en && (q.size() > 0);
        ns    = m_state;
        store = 0;
        if (m_state == 1) begin
            tnow  = in_valid && match;
            store = elig || tnow;
            if (tnow) begin
                m_trg  = 1;
                m_left = PT - 1;
                ns     = (m_left == 0) ? 3 : 2;
            end
        end else if (m_state == 2) begin
            if (m_mode == 1) begin
                store = elig && ((q.size() < D) || dop);
            end else begin
                store = elig;
                if (m_mode == 2 && store) begin
                    m_left--;
                    if (m_left == 0) ns = 3;
                end
            end
        end
        m_rdv = dop;
        if (dop) begin
            m_rdi = q[0].instr;
            m_rdp = q[0].pc;
            void'(q.pop_front());
        end
        if (store) begin
            if (q.size() == D) begin
                void'(q.pop_front());
                if (m_mode != 2) m_ovf = 1;
            end
            e.instr = in_instr;
            e.pc    = in_pc;
            q.push_back(e);
            if (m_mode == 1 && m_state == 2 && q.size() == D) ns = 3;
        end
        if (stop) ns = 3;
        m_state = ns;
    endtask

    task automatic check_all();
        chk("rd_valid",  64'(rd_valid),  64'(m_rdv));
        chk("rd_instr",  64'(rd_instr),  64'(m_rdi));
        chk("rd_pc",     rd_pc,          m_rdp);
        chk("count",     64'(count),     64'(q.size()));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        chk("triggered", 64'(triggered), 64'(m_trg));
        chk("state",     64'(state),     64'(m_state));
    endtask

    task automatic step(input logic a, input logic s, input logic v,
                        input logic [IW-1:0] ins, input logic [PW-1:0] pc, input logic r);
        arm = a; stop = s; in_valid = v; in_instr = ins; in_pc = pc; rd_en = r;
        model_step();
        @(posedge clk);
        #1;
        arm = 0; stop = 0; in_valid = 0; rd_en = 0;
        check_all();
    endtask

    function automatic logic [IW-1:0] mk(input logic [6:0] op);
        logic [24:0] hi;
        hi = 25'($urandom());
        return {hi, op};
    endfunction

    task automatic arm_with(input logic [1:0] md, input logic f, input logic [6:0] op, input logic [6:0] msk);
        mode = md; filt_en = f; match_op = op; match_mask = msk;
        step(1, 0, 0, '0, '0, 0);
    endtask

    initial begin
        reset = 1; arm = 0; stop = 0; mode = 0; filt_en = 0;
        match_op = 0; match_mask = 0; in_valid = 0; in_instr = 0; in_pc = 0; rd_en = 0;
        model_reset();
        #12;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_pc", rd_pc, 64'd0);
        @(posedge clk);
        #1 reset = 0;

        // wrap with overflow
        arm_with(2'd0, 0, OP_R, 7'h7f);
        for (int i = 0; i < 6; i++) step(0, 0, 1, mk(OP_ADDI), 64'(i * 4), 0);
        chk("t1_count", 64'(count), 64'd4);
        chk("t1_ovf", 64'(overflow), 64'd1);
        chk("t1_state", 64'(state), 64'd2);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, '0, '0, 1);
            chk("t1_rdv", 64'(rd_valid), 64'd1);
            chk("t1_pc", rd_pc, 64'(8 + i * 4));
        end
        step(0, 0, 0, '0, '0, 1);
        chk("t1_empty_pop", 64'(rd_valid), 64'd0);

        // fill stops at depth
        arm_with(2'd1, 0, OP_R, 7'h7f);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, mk(OP_ADDI), 64'(i * 4), 0);
            if (i == 3) chk("t2_done", 64'(state), 64'd3);
        end
        chk("t2_count", 64'(count), 64'd4);
        chk("t2_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, '0, '0, 1);
            chk("t2_pc", rd_pc, 64'(i * 4));
        end

        // opcode filter
        arm_with(2'd0, 1, OP_R, 7'h7f);
        step(0, 0, 1, mk(OP_R), 64'h100, 0);
        step(0, 0, 1, mk(OP_ADDI), 64'h104, 0);
        step(0, 0, 1, mk(OP_R), 64'h108, 0);
        step(0, 0, 1, mk(OP_ADDI), 64'h10c, 0);
        step(0, 0, 1, mk(OP_R), 64'h110, 0);
        chk("t3_count", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, '0, '0, 1);
            chk("t3_op", 64'(rd_instr[6:0]), 64'(OP_R));
        end

        // trigger with pre/post history
        arm_with(2'd2, 0, OP_BEQ, 7'h7f);
        chk("t4_armed", 64'(state), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, mk(OP_ADDI), 64'(i * 4), 0);
        step(0, 0, 1, mk(OP_BEQ), 64'hc, 0);
        chk("t4_trig", 64'(triggered), 64'd1);
        chk("t4_cap", 64'(state), 64'd2);
        step(0, 0, 1, mk(OP_ADDI), 64'h10, 0);
        chk("t4_done", 64'(state), 64'd3);
        step(0, 0, 1, mk(OP_ADDI), 64'h14, 0);
        chk("t4_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, '0, '0, 1);
            chk("t4_pc", rd_pc, 64'(4 + i * 4));
            chk("t4_op", 64'(rd_instr[6:0]), 64'((i == 2) ? OP_BEQ : OP_ADDI));
        end

        // pop+write at full, then stop
        arm_with(2'd0, 0, OP_R, 7'h7f);
        for (int i = 0; i < 4; i++) step(0, 0, 1, mk(OP_ADDI), 64'(i * 4), 0);
        step(0, 0, 1, mk(OP_ADDI), 64'h10, 1);
        chk("t5_count", 64'(count), 64'd4);
        chk("t5_ovf", 64'(overflow), 64'd0);
        step(0, 1, 0, '0, '0, 0);
        chk("t5_stop", 64'(state), 64'd3);
        step(0, 0, 1, mk(OP_ADDI), 64'h14, 0);
        chk("t5_ignored", 64'(count), 64'd4);

        // asynchronous reset mid-capture
        arm_with(2'd0, 0, OP_R, 7'h7f);
        for (int i = 0; i < 3; i++) step(0, 0, 1, mk(OP_ADDI), 64'(i * 4), 0);
        step(0, 0, 0, '0, '0, 1);
        chk("t6_pre", 64'(count), 64'd2);
        #2 reset = 1;
        #1;
        model_reset();
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_state", 64'(state), 64'd0);
        chk("t6_rdv", 64'(rd_valid), 64'd0);
        @(posedge clk);
        #1 reset = 0;
        arm_with(2'd0, 0, OP_R, 7'h7f);
        step(0, 0, 1, mk(OP_LD), 64'h200, 0);
        step(0, 0, 0, '0, '0, 1);
        chk("t6_restart", rd_pc, 64'h200);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic a, s, v, r;
            logic [6:0] ops [4];
            ops[0] = OP_ADDI; ops[1] = OP_R; ops[2] = OP_BEQ; ops[3] = OP_LD;
            a = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            if (a) begin
                mode       = 2'($urandom_range(0, 3));
                filt_en    = 1'($urandom_range(0, 1));
                match_op   = ops[$urandom_range(0, 3)];
                match_mask = ($urandom_range(0, 3) == 0) ? 7'($urandom()) : 7'h7f;
            end
            step(a, s, v, mk(ops[$urandom_range(0, 3)]), {32'h0, $urandom()}, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
